lsu_align_splitter: RTL and testbench
=====================================

Name: lsu_align_splitter

Overview:
- Load/store front-end between the core datapath and the byte-addressable data memory; drives the memory's DMWr/DMCtrl/addr/DataWr inputs and consumes its combinational DataRd.
- Naturally aligned accesses pass through in one cycle.
- Misaligned halfword/word accesses are split into sequential single-byte memory accesses while the core is stalled; load results are reassembled and extended.
- Illegal DMCtrl codes are trapped; misaligned accesses are also trapped when splitting is disabled.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = flag them with err and perform no access.
- ADDR_W, 32, width of core and memory byte addresses.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a memory access this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_ctrl  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- stall  output  1  core must hold the request and PC stable.
- rsp_valid  output  1  load data valid on rsp_rdata this cycle.
- rsp_rdata  output  32  extended load result.
- err  output  1  one-cycle pulse for an illegal ctrl, a store with BU/HU, or a misaligned access when ALLOW_MISALIGNED=0.
- DMWr  output  1  memory write enable.
- DMCtrl  output  3  memory access type.
- mem_addr  output  ADDR_W  memory byte address.
- DataWr  output  32  memory write data.
- DataRd  input  32  memory read data (combinational).

Behaviour:
- Reset (async, any time): state=IDLE, byte counter=0, latched request=0, assembly register=0.
  - In IDLE with req_valid=0, outputs are: stall=0, rsp_valid=0, rsp_rdata=0, err=0, DMWr=0, DMCtrl=000, mem_addr=0, DataWr=0.
- Aligned: H with addr[0]=0, W with addr[1:0]=00, and any B/BU. In IDLE these are combinational pass-through:
  - DMCtrl=req_ctrl, mem_addr=req_addr, DataWr=req_wdata, DMWr=req_we.
  - Load: rsp_valid=1 and rsp_rdata=DataRd in the same cycle.
  - stall=0. Latency is 0 cycles; a store commits at the next rising edge.
- Misaligned with ALLOW_MISALIGNED=1: the request cycle C0 asserts stall=1 with DMWr=0.
  - At the end of C0, latch we, ctrl, addr and wdata; N = 2 (H/HU) or 4 (W); go to SPLIT with k=0.
- SPLIT, cycle Ck (k = 0..N-1):
  - mem_addr = latched addr + k (ADDR_W-bit wrap).
  - Store: DMCtrl=000, DMWr=1, DataWr[7:0] = wdata byte k.
  - Load: DMCtrl=100, DMWr=0; DataRd[7:0] is captured into assembly byte k at the end of the cycle.
  - stall=1 for k < N-1. On k = N-1: stall=0; for a load, rsp_valid=1 and rsp_rdata = the final assembly (byte N-1 taken directly from DataRd), sign-extended for H and zero-extended for HU. Then return to IDLE.
  - Total misaligned latency: N+1 cycles with stall high for N cycles.
- req_* inputs are ignored while in SPLIT; a new request is accepted only in IDLE.
- Illegal access (ctrl 011/110/111, or we=1 with ctrl 100/101):
  - err=1 for one cycle, DMWr=0, rsp_valid=0, stall=0, state stays IDLE.
- Misaligned with ALLOW_MISALIGNED=0: err=1, no memory access, stall=0.
- Reset during SPLIT: aborts immediately with no response. Bytes already stored remain in memory (partial store is accepted behaviour).
- Address wrap: misaligned splitting across 0xFFFFFFFF wraps to 0x00000000. The memory truncates addresses itself.

Test Plan:
- Preload mem[0x100..0x103] = EF BE AD DE. LW at 0x100 -> same cycle rsp_valid=1, rsp_rdata=0xDEADBEEF, stall never asserted.
- SW 0x11223344 at 0x101 -> stall high for 4 cycles, bytes 44,33,22,11 written to 0x101..0x104 on successive edges; then LW 0x101 (split) -> rsp_rdata=0x11223344 after 5 cycles.
- mem[0x203]=0x80, mem[0x204]=0xFF:
  - LH 0x203 -> rsp_rdata=0xFFFFFF80 on the third cycle.
  - LHU 0x203 -> 0x0000FF80.
- req_ctrl=011 load, then SH with ctrl=101 -> err pulses one cycle each, DMWr stays 0, memory unchanged.
- ALLOW_MISALIGNED=0: LW at 0x102 -> err=1 in the request cycle, stall=0, rsp_valid=0.
- Reset asserted during the 3rd byte of SW 0xAABBCCDD at 0x301 -> outputs return to reset values asynchronously, mem[0x301]=DD and mem[0x302]=CC, mem[0x303] unchanged; the next aligned LB completes normally.

Source files
------------

// File: rtl/lsu_align_splitter.sv
// Load/store front-end: passes aligned accesses straight to data memory and
// splits misaligned halfword/word accesses into sequential byte accesses.
module lsu_align_splitter #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              err,
  output logic              DMWr,
  output logic [2:0]        DMCtrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       DataWr,
  input  logic [31:0]       DataRd
);

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

  state_t              state, state_n;
  logic [1:0]          k, k_n;
  logic                l_we;
  logic [2:0]          l_ctrl;
  logic [ADDR_W-1:0]   l_addr;
  logic [31:0]         l_wdata;
  logic [23:0]         asm_q;
  logic                latch;

  logic                illegal;
  logic                misal;
  logic                last;
  logic [31:0]         wsh;
  logic [15:0]         half;
  logic [31:0]         asm_rd;

  assign illegal = (req_ctrl == 3'b011) ||
                   (req_ctrl[2:1] == 2'b11) ||
                   (req_we && req_ctrl[2]);

  assign misal = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign last = l_ctrl[1] ? (k == 2'd3) : (k == 2'd1);
  assign wsh  = l_wdata >> {k, 3'b000};
  assign half = {DataRd[7:0], asm_q[7:0]};

  // final byte comes straight from memory so the result is ready this cycle
  always_comb begin
    asm_rd = '0;
    unique case (1'b1)
      l_ctrl[1]: asm_rd = {DataRd[7:0], asm_q};
      l_ctrl[2]: asm_rd = {16'h0000, half};
      default:   asm_rd = {{16{half[15]}}, half};
    endcase
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    latch     = 1'b0;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    err       = 1'b0;
    DMWr      = 1'b0;
    DMCtrl    = 3'b000;
    mem_addr  = '0;
    DataWr    = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            err = 1'b1;
          end else if (misal) begin
            if (ALLOW_MISALIGNED) begin
              stall   = 1'b1;
              latch   = 1'b1;
              k_n     = 2'd0;
              state_n = SPLIT;
            end else begin
              err = 1'b1;
            end
          end else begin
            DMCtrl    = req_ctrl;
            mem_addr  = req_addr;
            DataWr    = req_wdata;
            DMWr      = req_we;
            rsp_valid = ~req_we;
            rsp_rdata = req_we ? 32'h0 : DataRd;
          end
        end
      end
      SPLIT: begin
        mem_addr = l_addr + {{(ADDR_W-2){1'b0}}, k};
        DMCtrl   = l_we ? 3'b000 : 3'b100;
        DMWr     = l_we;
        DataWr   = l_we ? {24'h0, wsh[7:0]} : 32'h0;
        stall    = ~last;
        if (last) begin
          state_n   = IDLE;
          k_n       = 2'd0;
          rsp_valid = ~l_we;
          rsp_rdata = l_we ? 32'h0 : asm_rd;
        end else begin
          k_n = k + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      l_we    <= 1'b0;
      l_ctrl  <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      asm_q   <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      if (latch) begin
        l_we    <= req_we;
        l_ctrl  <= req_ctrl;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
      end
      if (state == SPLIT && !last) begin
        unique case (k)
          2'd0:    asm_q[7:0]   <= DataRd[7:0];
          2'd1:    asm_q[15:8]  <= DataRd[7:0];
          default: asm_q[23:16] <= DataRd[7:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_align_splitter.sv
// Scoreboard bench for lsu_align_splitter with a byte-addressed memory model.
module tb_lsu_align_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, err, DMWr;
  logic [31:0] rsp_rdata, DataWr, DataRd;
  logic [2:0]  DMCtrl;
  logic [31:0] mem_addr;

  logic        req_valid0, req_we0;
  logic [2:0]  req_ctrl0;
  logic [31:0] req_addr0, req_wdata0;
  logic        stall0, rsp_valid0, err0, DMWr0;
  logic [31:0] rsp_rdata0, DataWr0;
  logic [2:0]  DMCtrl0;
  logic [31:0] mem_addr0;
  logic [31:0] DataRd0;

  logic [7:0]  mem [4096];
  logic [31:0] q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu_align_splitter #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_ctrl(req_ctrl),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err(err), .DMWr(DMWr), .DMCtrl(DMCtrl), .mem_addr(mem_addr),
    .DataWr(DataWr), .DataRd(DataRd)
  );

  lsu_align_splitter #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_we(req_we0), .req_ctrl(req_ctrl0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .stall(stall0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .err(err0), .DMWr(DMWr0), .DMCtrl(DMCtrl0), .mem_addr(mem_addr0),
    .DataWr(DataWr0), .DataRd(DataRd0)
  );

  assign DataRd0 = 32'h0;

  // memory model: truncates to 12 address bits, extends on read
  always_comb begin
    logic [11:0] a;
    a = mem_addr[11:0];
    DataRd = 32'h0;
    case (DMCtrl)
      3'b000: DataRd = {{24{mem[a][7]}}, mem[a]};
      3'b100: DataRd = {24'h0, mem[a]};
      3'b001: DataRd = {{16{mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
      3'b101: DataRd = {16'h0, mem[a+12'd1], mem[a]};
      3'b010: DataRd = {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
      default: DataRd = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    logic [11:0] a;
    a = mem_addr[11:0];
    if (DMWr) begin
      mem[a] <= DataWr[7:0];
      if (DMCtrl[1:0] != 2'b00) mem[a+12'd1] <= DataWr[15:8];
      if (DMCtrl[1:0] == 2'b10) begin
        mem[a+12'd2] <= DataWr[23:16];
        mem[a+12'd3] <= DataWr[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: every load response is matched against the scoreboard queue
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%h required=none", rsp_rdata);
      end else begin
        chk("rsp_rdata", rsp_rdata, q.pop_front());
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_stall, input string name);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, n, exp_stall);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_ctrl = 0; req_addr = 0; req_wdata = 0;
    req_valid0 = 0; req_we0 = 0; req_ctrl0 = 0; req_addr0 = 0; req_wdata0 = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'hEF; mem[12'h101] = 8'hBE;
    mem[12'h102] = 8'hAD; mem[12'h103] = 8'hDE;
    mem[12'h203] = 8'h80; mem[12'h204] = 8'hFF;
    mem[12'h303] = 8'h77;
    mem[12'hFFF] = 8'h34; mem[12'h000] = 8'h12;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {stall, rsp_valid, err, DMWr, DMCtrl, rsp_rdata | mem_addr | DataWr},
        39'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_outputs",
        {stall, rsp_valid, err, DMWr, DMCtrl, rsp_rdata | mem_addr | DataWr},
        39'h0);

    q.push_back(32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 0, "lw_aligned");

    issue(1'b1, 3'b010, 32'h101, 32'h11223344, 4, "sw_mis");
    chk("sw_mis_mem", {mem[12'h104], mem[12'h103], mem[12'h102], mem[12'h101]},
        32'h11223344);

    q.push_back(32'h11223344);
    issue(1'b0, 3'b010, 32'h101, 32'h0, 4, "lw_mis");

    q.push_back(32'hFFFFFF80);
    issue(1'b0, 3'b001, 32'h203, 32'h0, 2, "lh_mis");
    q.push_back(32'h0000FF80);
    issue(1'b0, 3'b101, 32'h203, 32'h0, 2, "lhu_mis");

    q.push_back(32'h00001234);
    issue(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 2, "lhu_wrap");

    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b011; req_addr = 32'h100;
    @(negedge clk);
    chk("illegal_ld", {err, DMWr, rsp_valid, stall}, 4'b1000);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("illegal_ld_pulse", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b101;
    req_addr = 32'h100; req_wdata = 32'h5555;
    @(negedge clk);
    chk("illegal_st", {err, DMWr, rsp_valid, stall}, 4'b1000);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("illegal_st_pulse", {31'h0, err}, 32'h0);
    chk("illegal_st_mem", {mem[12'h101], mem[12'h100]}, 16'h44EF);
    @(posedge clk);
    #1;

    req_valid0 = 1'b1; req_we0 = 1'b0; req_ctrl0 = 3'b010; req_addr0 = 32'h102;
    @(negedge clk);
    chk("nomis_lw", {err0, stall0, rsp_valid0, DMWr0}, 4'b1000);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("nomis_pulse", {31'h0, err0}, 32'h0);
    @(posedge clk);
    #1;

    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010;
    req_addr = 32'h301; req_wdata = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("split_3rd_byte", {stall, DMWr, mem_addr[11:0], DataWr[7:0]},
        {2'b11, 12'h303, 8'hBB});
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("async_reset_outputs",
        {stall, rsp_valid, err, DMWr, DMCtrl, rsp_rdata | mem_addr | DataWr},
        39'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("partial_store_mem", {mem[12'h303], mem[12'h302], mem[12'h301]},
        24'h77CCDD);

    q.push_back(32'hFFFFFFDD);
    issue(1'b0, 3'b000, 32'h301, 32'h0, 0, "lb_after_reset");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
